// File: rtl/aurva_ctrl_s_axi.sv
// aurva_ctrl_s_axi -- AXI4-Lite control register file for the Aurva NTT kernel.
// Turns host register accesses into ap_start, the scalar 'start' argument and the
// 64-bit buffer pointer. It also latches the core's done/ready/idle status for polling
// and drives a level interrupt. Single clock domain (ap_clk), async active-high reset.
// Ports:
//   ap_clk, areset          clock / asynchronous active-high reset
//   s_axi_aw*/w*/b*         AXI4-Lite write channels (one write outstanding)
//   s_axi_ar*/r*            AXI4-Lite read channels (one read outstanding)
//   interrupt               registered GIE & |ISR
//   ap_start                start request to the core
//   ap_done/ap_ready/ap_idle  core status (pulses / level)
//   start, axi_ptr0         kernel arguments
module aurva_ctrl_s_axi #(
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            ap_clk,
    input  logic                            areset,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    output logic [1:0]                      s_axi_bresp,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            interrupt,
    output logic                            ap_start,
    input  logic                            ap_done,
    input  logic                            ap_ready,
    input  logic                            ap_idle,
    output logic                            start,
    output logic [63:0]                     axi_ptr0
);
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    // Word addresses (byte address >> 2)
    localparam logic [AW-3:0] A_CTRL  = (AW-2)'(6'h00 >> 2);
    localparam logic [AW-3:0] A_GIE   = (AW-2)'(6'h04 >> 2);
    localparam logic [AW-3:0] A_IER   = (AW-2)'(6'h08 >> 2);
    localparam logic [AW-3:0] A_ISR   = (AW-2)'(6'h0C >> 2);
    localparam logic [AW-3:0] A_START = (AW-2)'(6'h10 >> 2);
    localparam logic [AW-3:0] A_PTRL  = (AW-2)'(6'h14 >> 2);
    localparam logic [AW-3:0] A_PTRH  = (AW-2)'(6'h18 >> 2);

    typedef enum logic [1:0] {WRIDLE, WRDATA, WRRESP} wstate_t;
    typedef enum logic {RDIDLE, RDDATA} rstate_t;

    wstate_t wstate, wstate_nxt;
    rstate_t rstate, rstate_nxt;
    logic [AW-3:0] waddr;
    logic        auto_restart, done_lat, ready_lat, gie;
    logic [1:0]  ier, isr;
    logic [31:0] rdata_nxt;
    logic        wr_en, ar_hs;

    assign s_axi_bresp = 2'b00;
    assign s_axi_rresp = 2'b00;
    assign ar_hs = s_axi_arvalid & s_axi_arready;
    assign wr_en = s_axi_wvalid & s_axi_wready;

    // ---------------- write FSM ----------------
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) wstate <= WRIDLE;
        else        wstate <= wstate_nxt;
    end

    always_comb begin
        wstate_nxt    = wstate;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (wstate)
            WRIDLE: begin
                s_axi_awready = 1'b1;
                if (s_axi_awvalid) wstate_nxt = WRDATA;
            end
            WRDATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid) wstate_nxt = WRRESP;
            end
            WRRESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) wstate_nxt = WRIDLE;
            end
            default: wstate_nxt = WRIDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset)                                waddr <= '0;
        else if (s_axi_awvalid && s_axi_awready)   waddr <= s_axi_awaddr[AW-1:2];
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) rstate <= RDIDLE;
        else        rstate <= rstate_nxt;
    end

    always_comb begin
        rstate_nxt    = rstate;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (rstate)
            RDIDLE: begin
                s_axi_arready = 1'b1;
                if (s_axi_arvalid) rstate_nxt = RDDATA;
            end
            RDDATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) rstate_nxt = RDIDLE;
            end
            default: rstate_nxt = RDIDLE;
        endcase
    end

    // Read mux uses the current (pre-update) register values.
    always_comb begin
        rdata_nxt = '0;
        case (s_axi_araddr[AW-1:2])
            A_CTRL:  rdata_nxt = {24'b0, auto_restart, 3'b0, ready_lat, ap_idle, done_lat, ap_start};
            A_GIE:   rdata_nxt = {31'b0, gie};
            A_IER:   rdata_nxt = {30'b0, ier};
            A_ISR:   rdata_nxt = {30'b0, isr};
            A_START: rdata_nxt = {31'b0, start};
            A_PTRL:  rdata_nxt = axi_ptr0[31:0];
            A_PTRH:  rdata_nxt = axi_ptr0[63:32];
            default: rdata_nxt = '0;
        endcase
    end

    // rdata only changes on the AR handshake, so it stays stable until rready.
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset)     s_axi_rdata <= '0;
        else if (ar_hs) s_axi_rdata <= rdata_nxt;
    end

    // ---------------- registers ----------------
    logic ctrl_rd, wr_ctrl0;
    assign ctrl_rd  = ar_hs && (s_axi_araddr[AW-1:2] == A_CTRL);
    assign wr_ctrl0 = wr_en && (waddr == A_CTRL) && s_axi_wstrb[0];

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            ap_start     <= 1'b0;
            auto_restart <= 1'b0;
            done_lat     <= 1'b0;
            ready_lat    <= 1'b0;
            gie          <= 1'b0;
            ier          <= '0;
            isr          <= '0;
            start        <= 1'b0;
            axi_ptr0     <= '0;
            interrupt    <= 1'b0;
        end else begin
            // Host write of 1 starts; writing 0 never stops a running request.
            if (wr_ctrl0 && s_axi_wdata[0])      ap_start <= 1'b1;
            else if (ap_ready && !auto_restart)  ap_start <= 1'b0;
            if (wr_ctrl0) auto_restart <= s_axi_wdata[7];

            // Status latches: a pulse in the same cycle as the clearing read wins.
            if (ap_done)      done_lat <= 1'b1;
            else if (ctrl_rd) done_lat <= 1'b0;
            if (ap_ready)     ready_lat <= 1'b1;
            else if (ctrl_rd) ready_lat <= 1'b0;

            if (wr_en && s_axi_wstrb[0]) begin
                if (waddr == A_GIE)   gie   <= s_axi_wdata[0];
                if (waddr == A_IER)   ier   <= s_axi_wdata[1:0];
                if (waddr == A_START) start <= s_axi_wdata[0];
            end

            // ISR: enabled event sets, host write of 1 toggles; set dominates.
            for (int i = 0; i < 2; i++) begin
                if ((i == 0 ? ap_done : ap_ready) && ier[i])
                    isr[i] <= 1'b1;
                else if (wr_en && waddr == A_ISR && s_axi_wstrb[0] && s_axi_wdata[i])
                    isr[i] <= ~isr[i];
            end

            for (int b = 0; b < 4; b++) begin
                if (wr_en && s_axi_wstrb[b]) begin
                    if (waddr == A_PTRL) axi_ptr0[b*8 +: 8]      <= s_axi_wdata[b*8 +: 8];
                    if (waddr == A_PTRH) axi_ptr0[32 + b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end

            interrupt <= gie & (|isr);
        end
    end
endmodule

// File: tb/tb_aurva_ctrl_s_axi.sv
// Directed self-checking bench for aurva_ctrl_s_axi.
module tb_aurva_ctrl_s_axi;
    logic        ap_clk = 1'b0;
    logic        areset = 1'b1;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [5:0]  awaddr = '0, araddr = '0;
    logic [31:0] wdata = '0, rdata;
    logic [3:0]  wstrb = '0;
    logic [1:0]  bresp, rresp;
    logic        interrupt, ap_start, start;
    logic        ap_done = 0, ap_ready = 0, ap_idle = 0;
    logic [63:0] axi_ptr0;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;
    logic [1:0]  rsp;

    always #5 ap_clk = ~ap_clk;

    aurva_ctrl_s_axi dut (
        .ap_clk(ap_clk), .areset(areset),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .interrupt(interrupt), .ap_start(ap_start), .ap_done(ap_done), .ap_ready(ap_ready),
        .ap_idle(ap_idle), .start(start), .axi_ptr0(axi_ptr0)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All stimulus changes and samples happen on the falling edge.
    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        awvalid = 1; awaddr = a;
        for (n = 0; n < 20 && !awready; n++) @(negedge ap_clk);
        if (n == 20) chk("aw_timeout", 0, 1);
        @(negedge ap_clk);
        awvalid = 0; wvalid = 1; wdata = d; wstrb = s;
        for (n = 0; n < 20 && !wready; n++) @(negedge ap_clk);
        if (n == 20) chk("w_timeout", 0, 1);
        @(negedge ap_clk);
        wvalid = 0; bready = 1;
        for (n = 0; n < 20 && !bvalid; n++) @(negedge ap_clk);
        if (n == 20) chk("b_timeout", 0, 1);
        chk("bresp", bresp, 0);
        @(negedge ap_clk);
        bready = 0;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        arvalid = 1; araddr = a;
        for (n = 0; n < 20 && !arready; n++) @(negedge ap_clk);
        if (n == 20) chk("ar_timeout", 0, 1);
        @(negedge ap_clk);
        arvalid = 0; rready = 1;
        for (n = 0; n < 20 && !rvalid; n++) @(negedge ap_clk);
        if (n == 20) chk("r_timeout", 0, 1);
        d = rdata; r = rresp;
        @(negedge ap_clk);
        rready = 0;
    endtask

    task automatic pulse(input int which);
        if (which == 0) ap_done = 1; else ap_ready = 1;
        @(negedge ap_clk);
        ap_done = 0; ap_ready = 0;
    endtask

    initial begin
        repeat (3) @(negedge ap_clk);
        areset = 0;
        @(negedge ap_clk);
        // reset state
        chk("rst_awready", awready, 1);
        chk("rst_arready", arready, 1);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ap_start", ap_start, 0);
        chk("rst_interrupt", interrupt, 0);
        chk("rst_ptr", axi_ptr0, 0);

        // 1: pointer writes, readback, byte strobes, unmapped
        axi_write(6'h14, 32'hDEAD_BEEF, 4'hF);
        axi_write(6'h18, 32'h0000_0001, 4'hF);
        chk("ptr", axi_ptr0, 64'h1_DEAD_BEEF);
        axi_read(6'h14, rd, rsp);
        chk("ptr_lo_rd", rd, 32'hDEAD_BEEF);
        chk("rresp", rsp, 0);
        axi_read(6'h18, rd, rsp);
        chk("ptr_hi_rd", rd, 32'h1);
        axi_write(6'h14, 32'hAAAA_AAAA, 4'b0010);
        chk("ptr_strb", axi_ptr0, 64'h1_DEAD_AAEF);
        axi_write(6'h1C, 32'hFFFF_FFFF, 4'hF);
        axi_read(6'h1C, rd, rsp);
        chk("unmapped_rd", rd, 0);
        chk("unmapped_rresp", rsp, 0);
        chk("unmapped_nowr", axi_ptr0, 64'h1_DEAD_AAEF);

        // 2: start / done / ready, clear-on-read
        axi_write(6'h10, 32'h1, 4'hF);
        chk("scalar_start", start, 1);
        axi_write(6'h00, 32'h1, 4'h1);
        chk("ap_start_set", ap_start, 1);
        ap_ready = 1; ap_done = 1;
        @(negedge ap_clk);
        ap_ready = 0; ap_done = 0;
        chk("ap_start_clr", ap_start, 0);
        axi_read(6'h00, rd, rsp);
        chk("ctrl_rd1", rd, 32'h0000_000A);
        axi_read(6'h00, rd, rsp);
        chk("ctrl_rd2", rd, 32'h0);

        // 3: interrupt path
        axi_write(6'h04, 32'h1, 4'hF);
        axi_write(6'h08, 32'h1, 4'hF);
        chk("irq_idle", interrupt, 0);
        pulse(0);
        chk("irq_lag", interrupt, 0);
        @(negedge ap_clk);
        chk("irq_set", interrupt, 1);
        axi_read(6'h0C, rd, rsp);
        chk("isr_rd", rd, 32'h1);
        axi_write(6'h0C, 32'h1, 4'hF);
        axi_read(6'h0C, rd, rsp);
        chk("isr_toggled", rd, 32'h0);
        chk("irq_clr", interrupt, 0);

        // 4: auto_restart
        axi_read(6'h00, rd, rsp);
        chk("ctrl_pre4", rd, 32'h02);
        axi_write(6'h00, 32'h81, 4'h1);
        repeat (3) pulse(1);
        chk("auto_hold", ap_start, 1);
        ap_idle = 1;
        axi_read(6'h00, rd, rsp);
        ap_idle = 0;
        chk("ctrl_auto_rd", rd, 32'h8D);
        axi_write(6'h00, 32'h00, 4'h1);
        chk("wr0_no_stop", ap_start, 1);
        pulse(1);
        chk("auto_off_clr", ap_start, 0);

        // 5: done pulse coincident with the clearing read
        axi_read(6'h00, rd, rsp);
        chk("ctrl_pre5", rd, 32'h08);
        arvalid = 1; araddr = 6'h00; ap_done = 1;
        @(negedge ap_clk);
        arvalid = 0; ap_done = 0; rready = 1;
        chk("race_rvalid", rvalid, 1);
        chk("race_rd", rdata[1], 0);
        @(negedge ap_clk);
        rready = 0;
        axi_read(6'h00, rd, rsp);
        chk("race_next", rd[1], 1);

        // 6: reset in the middle of a write
        axi_write(6'h00, 32'h1, 4'h1);
        chk("pre6_irq", interrupt, 1);
        chk("pre6_start", ap_start, 1);
        awvalid = 1; awaddr = 6'h14;
        @(negedge ap_clk);
        awvalid = 0;
        chk("mid_wready", wready, 1);
        areset = 1;
        #1;
        chk("arst_wready", wready, 0);
        chk("arst_bvalid", bvalid, 0);
        chk("arst_ap_start", ap_start, 0);
        chk("arst_irq", interrupt, 0);
        chk("arst_ptr", axi_ptr0, 0);
        chk("arst_start", start, 0);
        @(negedge ap_clk);
        @(negedge ap_clk);
        areset = 0;
        @(negedge ap_clk);
        chk("post_awready", awready, 1);
        chk("post_arready", arready, 1);
        chk("post_rdata", rdata, 0);
        axi_write(6'h14, 32'h1234_5678, 4'hF);
        axi_read(6'h14, rd, rsp);
        chk("post_wr_rd", rd, 32'h1234_5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
